adder_tree_job_scheduler: RTL and testbench

- Shares one pipelined 16-input, 32-bit-result adder tree among NUM_REQ requesters.
- Arbitrates whole jobs. A job is a burst of `len` operand beats.
- Per granted job: drives the operand-mux select and beat acks, tracks the tree's fixed latency with an internal valid/tag pipe, and accumulates the per-beat tree sums into one result.
- Sits between the requester FIFOs and the operand mux feeding the adder tree.

---
 rtl/adder_tree_job_scheduler_pkg.sv | 20 ++
 rtl/adder_tree_job_scheduler_if.sv | 31 +++
 rtl/adder_tree_job_arbiter.sv | 56 +++++
 rtl/adder_tree_job_scheduler.sv | 136 +++++++++++++
 tb/tb_adder_tree_job_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_tree_job_scheduler_pkg.sv
// Shared types and defaults for the adder-tree job scheduler.
// Optional feature macro (see arbiter/top): ADDER_TREE_SCHED_RR_EN.
package adder_tree_job_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } sched_state_t;

   localparam int DEF_TREE_LAT = 4;
   localparam int DEF_SUM_W    = 32;

   // Requester index width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder_tree_job_scheduler_if.sv
// Requester, adder-tree and result signals of the job scheduler.
// slave = scheduler side, master = requesters/tree/consumer side.
interface adder_tree_job_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int LEN_W   = 8,
   parameter int SUM_W   = 32,
   parameter int ACC_W   = 40
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*LEN_W-1:0] req_len;
   logic [NUM_REQ-1:0]       beat_ack;
   logic [ID_W-1:0]          tree_sel;
   logic                     tree_issue;
   logic [SUM_W-1:0]         tree_sum;
   logic                     result_valid;
   logic                     result_ready;
   logic [ACC_W-1:0]         result_data;
   logic [ID_W-1:0]          result_id;
   logic                     busy;

   modport slave (
      input  req_valid, req_len, tree_sum, result_ready,
      output beat_ack, tree_sel, tree_issue, result_valid, result_data, result_id, busy
   );

   modport master (
      output req_valid, req_len, tree_sum, result_ready,
      input  beat_ack, tree_sel, tree_issue, result_valid, result_data, result_id, busy
   );
endinterface

// File: rtl/adder_tree_job_arbiter.sv
// Winner select for the job scheduler: fixed priority (lowest index) by default,
// round-robin starting after the last owner when ADDER_TREE_SCHED_RR_EN is defined.
module adder_tree_job_arbiter
   import adder_tree_job_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
`ifdef ADDER_TREE_SCHED_RR_EN
   input  logic               clk,
   input  logic               reset,
   input  logic               take,
`endif
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any_req
);

   localparam int SW = ID_W + 1;

   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] rot;
   logic [ID_W-1:0]    off;
   logic [SW-1:0]      sum;

`ifdef ADDER_TREE_SCHED_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (take && any_req)
         ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   end
`else
   assign ptr = '0;
`endif

   // Rotate so bit 0 is the search start, take the first set bit, rotate back.
   always_comb begin
      rot      = NUM_REQ'({req_valid, req_valid} >> ptr);
      off      = '0;
      any_req  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_req && rot[k]) begin
            any_req = 1'b1;
            off     = ID_W'(k);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= SW'(NUM_REQ))
         sum = sum - SW'(NUM_REQ);
      grant_id = ID_W'(sum);
      grant    = any_req ? (NUM_REQ'(1) << grant_id) : '0;
   end

endmodule

// File: rtl/adder_tree_job_scheduler.sv
// Shares one pipelined adder tree among NUM_REQ requesters, one whole job at a time,
// accumulating tree sums tracked by a valid pipe. Macro: ADDER_TREE_SCHED_RR_EN (round-robin).
//
// state | meaning
// IDLE  | waiting for any req_valid; grant, latch owner/len, clear accumulator
// ISSUE | one beat per cycle to the tree, len cycles back-to-back
// DRAIN | waiting for the valid pipe to empty and the last sum to land
// DONE  | result presented and held until result_ready
module adder_tree_job_scheduler
   import adder_tree_job_scheduler_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_W     = id_width(NUM_REQ),
   parameter int LEN_W    = 8,
   parameter int TREE_LAT = DEF_TREE_LAT,
   parameter int SUM_W    = DEF_SUM_W,
   parameter int ACC_W    = 40
) (
   input logic clk,
   input logic reset,
   adder_tree_job_scheduler_if.slave bus
);

   sched_state_t       state, state_nxt;
   logic [ID_W-1:0]    owner;
   logic [LEN_W-1:0]   remain;
   logic [ACC_W-1:0]   acc;
   logic [TREE_LAT-1:0] vpipe;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               any_req;
   logic               grant_take;
   logic [LEN_W-1:0]   sel_len;

   logic [NUM_REQ-1:0] beat_ack_c;
   logic [ID_W-1:0]    tree_sel_c;
   logic               tree_issue_c;
   logic               result_valid_c;
   logic [ACC_W-1:0]   result_data_c;
   logic [ID_W-1:0]    result_id_c;

   adder_tree_job_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
`ifdef ADDER_TREE_SCHED_RR_EN
      .clk       (clk),
      .reset     (reset),
      .take      (grant_take),
`endif
      .req_valid (bus.req_valid),
      .grant     (grant),
      .grant_id  (grant_id),
      .any_req   (any_req)
   );

   always_comb begin
      sel_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i])
            sel_len = bus.req_len[i*LEN_W +: LEN_W];
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_take     = 1'b0;
      beat_ack_c     = '0;
      tree_sel_c     = '0;
      tree_issue_c   = 1'b0;
      result_valid_c = 1'b0;
      result_data_c  = '0;
      result_id_c    = '0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               grant_take = 1'b1;
               state_nxt  = (sel_len == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tree_issue_c = 1'b1;
            tree_sel_c   = owner;
            beat_ack_c   = NUM_REQ'(1) << owner;
            if (remain == LEN_W'(1))
               state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Only the tail bit may remain: its add lands on the same edge we leave.
            if (vpipe[TREE_LAT-2:0] == '0)
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            result_valid_c = 1'b1;
            result_data_c  = acc;
            result_id_c    = owner;
            if (bus.result_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         owner  <= '0;
         remain <= '0;
         acc    <= '0;
         vpipe  <= '0;
      end else begin
         state <= state_nxt;
         vpipe <= {vpipe[TREE_LAT-2:0], tree_issue_c};
         if (grant_take) begin
            owner  <= grant_id;
            remain <= sel_len;
            acc    <= '0;
         end else begin
            if (tree_issue_c)
               remain <= remain - 1'b1;
            if (vpipe[TREE_LAT-1])
               acc <= acc + ACC_W'(bus.tree_sum);
         end
      end
   end

   assign bus.beat_ack     = beat_ack_c;
   assign bus.tree_sel     = tree_sel_c;
   assign bus.tree_issue   = tree_issue_c;
   assign bus.result_valid = result_valid_c;
   assign bus.result_data  = result_data_c;
   assign bus.result_id    = result_id_c;
   assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_adder_tree_job_scheduler.sv
// Directed bench for adder_tree_job_scheduler with a delayed-sum tree model and result scoreboard.
module tb_adder_tree_job_scheduler;
   import adder_tree_job_scheduler_pkg::*;

   localparam int NUM_REQ  = 4;
   localparam int ID_W     = 2;
   localparam int LEN_W    = 8;
   localparam int TREE_LAT = DEF_TREE_LAT;
   localparam int SUM_W    = DEF_SUM_W;
   localparam int ACC_W    = 40;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic [ACC_W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   adder_tree_job_scheduler_if #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LEN_W(LEN_W), .SUM_W(SUM_W), .ACC_W(ACC_W)
   ) bus ();

   adder_tree_job_scheduler #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .LEN_W(LEN_W),
      .TREE_LAT(TREE_LAT), .SUM_W(SUM_W), .ACC_W(ACC_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t             sb [$];
   logic [SUM_W-1:0] ops [NUM_REQ][$];
   logic [SUM_W-1:0] dl [TREE_LAT];
   int cyc = 0;
   int last_issue = -1;
   int issue_cnt = 0;
   int ack_bad = 0;
   int ack_cnt [NUM_REQ] = '{default: 0};
   int n_checks = 0;
   int n_err = 0;

   // Tree model: the operand of a real beat appears at tree_sum TREE_LAT cycles later;
   // idle slots carry junk that must never be accumulated.
   always @(posedge clk) begin
      logic [SUM_W-1:0] op;
      op = 32'h5A5A_5A5A;
      if (bus.tree_issue === 1'b1) begin
         if (ops[bus.tree_sel].size() > 0)
            op = ops[bus.tree_sel].pop_front();
         last_issue <= cyc;
         issue_cnt  <= issue_cnt + 1;
      end
      if (bus.beat_ack !== ((bus.tree_issue === 1'b1) ? (NUM_REQ'(1) << bus.tree_sel) : NUM_REQ'(0)))
         ack_bad <= ack_bad + 1;
      for (int i = 0; i < NUM_REQ; i++)
         ack_cnt[i] <= ack_cnt[i] + int'(bus.beat_ack[i]);
      dl[0] <= op;
      for (int i = 1; i < TREE_LAT; i++)
         dl[i] <= dl[i-1];
      cyc <= cyc + 1;
   end

   assign bus.tree_sum = dl[TREE_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_len(input int r, input int len);
      bus.req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_beat_ack"},     bus.beat_ack, 0);
      check({tag, "_tree_sel"},     bus.tree_sel, 0);
      check({tag, "_tree_issue"},   bus.tree_issue, 0);
      check({tag, "_result_valid"}, bus.result_valid, 0);
      check({tag, "_result_data"},  bus.result_data, 0);
      check({tag, "_result_id"},    bus.result_id, 0);
      check({tag, "_busy"},         bus.busy, 0);
   endtask

   // Waits for a result, holds it for `hold` cycles, then accepts and compares against the scoreboard.
   task automatic collect(input string tag, input int hold, output int rise);
      exp_t e;
      int   n;
      n = 0;
      while (bus.result_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      rise = cyc;
      check({tag, "_valid"}, bus.result_valid, 1);
      if (bus.result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s_sb observed=unexpected_result expected=none", tag);
         end else begin
            e = sb.pop_front();
            for (int k = 0; k < hold; k++) begin
               tick();
               check({tag, "_hold_valid"}, bus.result_valid, 1);
               check({tag, "_hold_data"},  bus.result_data, e.data);
               check({tag, "_hold_id"},    bus.result_id, e.id);
               check({tag, "_hold_ack"},   bus.beat_ack, 0);
               check({tag, "_hold_busy"},  bus.busy, 1);
            end
            check({tag, "_data"}, bus.result_data, e.data);
            check({tag, "_id"},   bus.result_id, e.id);
         end
         bus.result_ready = 1'b1;
         tick();
         bus.result_ready = 1'b0;
         check({tag, "_drop"}, bus.result_valid, 0);
      end
   endtask

   initial begin
      int rise;
      int g;
      int ic0;

      bus.req_valid    = '0;
      bus.req_len      = '0;
      bus.result_ready = 1'b0;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      check_idle_outputs("reset");
      reset = 1'b0;
      tick();

      // Single job: requester 0, three beats 10+20+30
      ops[0] = '{32'd10, 32'd20, 32'd30};
      set_len(0, 3);
      sb.push_back('{id: 2'd0, data: 40'd60});
      bus.req_valid = 4'b0001;
      tick();
      check("single_beat1_ack", bus.beat_ack, 4'b0001);
      check("single_beat1_sel", bus.tree_sel, 0);
      check("single_beat1_issue", bus.tree_issue, 1);
      check("single_busy", bus.busy, 1);
      bus.req_valid = 4'b0000;
      tick();
      check("single_beat2_ack", bus.beat_ack, 4'b0001);
      tick();
      check("single_beat3_ack", bus.beat_ack, 4'b0001);
      tick();
      check("single_drain_ack", bus.beat_ack, 4'b0000);
      check("single_drain_issue", bus.tree_issue, 0);
      collect("single", 3, rise);
      check("single_latency", 64'(rise - last_issue), 64'(TREE_LAT + 1));
      check("single_ack_count", 64'(ack_cnt[0]), 3);

`ifndef ADDER_TREE_SCHED_RR_EN
      // Fixed priority: requester 1 always beats requester 3
      set_len(1, 2);
      set_len(3, 2);
      ops[1] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
      ops[3] = '{32'd99, 32'd99};
      sb.push_back('{id: 2'd1, data: 40'd3});
      sb.push_back('{id: 2'd1, data: 40'd7});
      sb.push_back('{id: 2'd1, data: 40'd11});
      bus.req_valid = 4'b1010;
      collect("prio1", 0, rise);
      collect("prio2", 0, rise);
      tick();
      bus.req_valid = 4'b0000;
      collect("prio3", 0, rise);
      check("prio_ack3_count", 64'(ack_cnt[3]), 0);
      check("prio_ack1_count", 64'(ack_cnt[1]), 6);
      ops[3].delete();
`endif

      // Zero length on requester 2
      ic0 = issue_cnt;
      set_len(2, 0);
      sb.push_back('{id: 2'd2, data: 40'd0});
      bus.req_valid = 4'b0100;
      g = cyc;
      tick();
      check("zero_issue", bus.tree_issue, 0);
      check("zero_ack", bus.beat_ack, 0);
      bus.req_valid = 4'b0000;
      collect("zero", 0, rise);
      check("zero_latency", 64'(rise - g), 1);
      check("zero_issue_count", 64'(issue_cnt - ic0), 0);
      check("zero_ack_count", 64'(ack_cnt[2]), 0);

      // Backpressure with a second job pending from the same requester
      set_len(0, 1);
      ops[0] = '{32'd9, 32'd4};
      sb.push_back('{id: 2'd0, data: 40'd9});
      sb.push_back('{id: 2'd0, data: 40'd4});
      bus.req_valid = 4'b0001;
      collect("bp", 10, rise);
      tick();
      check("bp_regrant_ack", bus.beat_ack, 4'b0001);
      bus.req_valid = 4'b0000;
      collect("bp2", 0, rise);

      // Reset in the middle of an 8-beat job, then a fresh job right after release
      set_len(0, 8);
      ops[0] = '{32'd1000, 32'd1001, 32'd1002, 32'd1003, 32'd1004, 32'd1005, 32'd1006, 32'd1007};
      bus.req_valid = 4'b0001;
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check_idle_outputs("abort");
      bus.req_valid = 4'b0000;
      ops[0].delete();
      tick();
      reset = 1'b0;
      set_len(0, 2);
      ops[0] = '{32'd5, 32'd7};
      sb.push_back('{id: 2'd0, data: 40'd12});
      bus.req_valid = 4'b0001;
      tick();
      bus.req_valid = 4'b0000;
      collect("post_reset", 0, rise);

`ifdef ADDER_TREE_SCHED_RR_EN
      // Round-robin from a freshly reset pointer: 0,1,2,3,0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) begin
         set_len(r, 1);
         ops[r] = '{SUM_W'(100 + r)};
      end
      ops[0].push_back(32'd200);
      sb.push_back('{id: 2'd0, data: 40'd100});
      sb.push_back('{id: 2'd1, data: 40'd101});
      sb.push_back('{id: 2'd2, data: 40'd102});
      sb.push_back('{id: 2'd3, data: 40'd103});
      sb.push_back('{id: 2'd0, data: 40'd200});
      bus.req_valid = 4'b1111;
      for (int k = 0; k < NUM_REQ; k++)
         collect("rr", 0, rise);
      tick();
      bus.req_valid = 4'b0000;
      collect("rr_wrap", 0, rise);
`endif

      check("ack_onehot_vs_issue", 64'(ack_bad), 0);
      check("scoreboard_empty", 64'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
